// File: rtl/inv_mix_columns.sv
// -----------------------------------------------------------------------------
// inv_mix_columns
//   Iterative AES-128 InvMixColumns stage for the decryption datapath.
//   A 128-bit state is captured on enable, one 32-bit column is transformed
//   per clock with the GF(2^8) matrix {0e,0b,0d,09}, and after four column
//   cycles the full result is loaded into 'mixed' with a one-cycle done_flag.
//
//   Byte ordering: byte b occupies bits [8b +: 8] of a [0:127] vector, so
//   byte 0 is the leftmost byte of a hex literal. Column c is bytes 4c..4c+3,
//   row 0 first.
//
//   Optional feature macro: INV_MIX_BYPASS_EN
//     defined   -> adds input 'bypass'; when captured high the column math is
//                  skipped and 'mixed' returns the captured state unchanged,
//                  with identical latency and handshake.
//     undefined -> no bypass port, every operation applies InvMixColumns.
//
// Ports
//   CLK        in   1        rising-edge clock
//   RST        in   1        asynchronous active-low reset
//   in         in   [0:127]  state to transform (sampled on accepted enable)
//   enable     in   1        start request, sampled only while idle
//   bypass     in   1        (INV_MIX_BYPASS_EN only) pass-through request
//   mixed      out  [0:127]  result register, held until next completion
//   done_flag  out  1        one-cycle pulse, 'mixed' valid while high
//   busy       out  1        high while columns are being processed
// -----------------------------------------------------------------------------
module inv_mix_columns (
    input  logic         CLK,
    input  logic         RST,
    input  logic [0:127] in,
    input  logic         enable,
`ifdef INV_MIX_BYPASS_EN
    input  logic         bypass,
`endif
    output logic [0:127] mixed,
    output logic         done_flag,
    output logic         busy
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_COL  = 1'b1
    } fsm_e;

    // GF(2^8) multiply by 2 with reduction polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul9(input logic [7:0] b);
        gf_mul9 = xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] gf_mulb(input logic [7:0] b);
        gf_mulb = xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gf_muld(input logic [7:0] b);
        gf_muld = xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] gf_mule(input logic [7:0] b);
        gf_mule = xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    // One column of InvMixColumns; s0 is in the top byte (row 0).
    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] s0, s1, s2, s3;
        logic [7:0] r0, r1, r2, r3;
        s0 = c[31:24];
        s1 = c[23:16];
        s2 = c[15:8];
        s3 = c[7:0];
        r0 = gf_mule(s0) ^ gf_mulb(s1) ^ gf_muld(s2) ^ gf_mul9(s3);
        r1 = gf_mul9(s0) ^ gf_mule(s1) ^ gf_mulb(s2) ^ gf_muld(s3);
        r2 = gf_muld(s0) ^ gf_mul9(s1) ^ gf_mule(s2) ^ gf_mulb(s3);
        r3 = gf_mulb(s0) ^ gf_muld(s1) ^ gf_mul9(s2) ^ gf_mule(s3);
        inv_mix_col = {r0, r1, r2, r3};
    endfunction

    fsm_e         fsm_q,   fsm_d;
    logic [1:0]   col_q,   col_d;
    logic [0:127] state_q, state_d;
    logic [0:127] acc_q,   acc_d;
    logic [0:127] mixed_q, mixed_d;
    logic         done_q,  done_d;
    logic         busy_q,  busy_d;
    logic         bypass_q, bypass_d;
    logic         bypass_in_s;

    logic [6:0]   col_base_s;
    logic [31:0]  col_in_s;
    logic [31:0]  col_res_s;
    logic [0:127] acc_full_s;

`ifdef INV_MIX_BYPASS_EN
    assign bypass_in_s = bypass;
`else
    assign bypass_in_s = 1'b0;
`endif

    // Single shared column datapath, steered by the column counter.
    always_comb begin
        col_base_s = {col_q, 5'd0};
        col_in_s   = state_q[col_base_s +: 32];
        col_res_s  = inv_mix_col(col_in_s);
        acc_full_s = acc_q;
        acc_full_s[col_base_s +: 32] = col_res_s;
    end

    // Next-state and output logic for the IDLE/COL sequencer.
    always_comb begin
        fsm_d    = fsm_q;
        col_d    = col_q;
        state_d  = state_q;
        acc_d    = acc_q;
        mixed_d  = mixed_q;
        done_d   = 1'b0;
        busy_d   = busy_q;
        bypass_d = bypass_q;
        case (fsm_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d  = in;
                    bypass_d = bypass_in_s;
                    col_d    = 2'd0;
                    busy_d   = 1'b1;
                    fsm_d    = ST_COL;
                end else begin
                    fsm_d = ST_IDLE;
                end
            end
            ST_COL: begin
                acc_d = acc_full_s;
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    // Load the complete result in one step so 'mixed'
                    // never exposes a partially transformed state.
                    mixed_d = bypass_q ? state_q : acc_full_s;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    fsm_d   = ST_IDLE;
                end else begin
                    fsm_d = ST_COL;
                end
            end
            default: begin
                fsm_d  = ST_IDLE;
                col_d  = 2'd0;
                busy_d = 1'b0;
            end
        endcase
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            fsm_q    <= ST_IDLE;
            col_q    <= 2'd0;
            state_q  <= 128'h0;
            acc_q    <= 128'h0;
            mixed_q  <= 128'h0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            bypass_q <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            col_q    <= col_d;
            state_q  <= state_d;
            acc_q    <= acc_d;
            mixed_q  <= mixed_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            bypass_q <= bypass_d;
        end
    end

    assign mixed     = mixed_q;
    assign done_flag = done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_inv_mix_columns.sv
module tb_inv_mix_columns;

    logic         CLK;
    logic         RST;
    logic [0:127] in;
    logic         enable;
    logic         bypass;
    logic [0:127] mixed;
    logic         done_flag;
    logic         busy;

    int n_total;
    int n_bad;
    logic [0:127] exp_q[$];

    inv_mix_columns dut (
        .CLK       (CLK),
        .RST       (RST),
        .in        (in),
        .enable    (enable),
`ifdef INV_MIX_BYPASS_EN
        .bypass    (bypass),
`endif
        .mixed     (mixed),
        .done_flag (done_flag),
        .busy      (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Shift-and-add GF(2^8) multiply, independent of any fixed constant chain.
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
        logic [7:0] a;
        logic [7:0] p;
        logic       hi;
        a = a_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
        end
        return p;
    endfunction

    function automatic logic [0:127] mix_fwd(input logic [0:127] s);
        logic [0:127] r;
        logic [7:0] s0, s1, s2, s3;
        for (int c = 0; c < 4; c++) begin
            s0 = s[32*c +: 8];
            s1 = s[32*c+8 +: 8];
            s2 = s[32*c+16 +: 8];
            s3 = s[32*c+24 +: 8];
            r[32*c +: 8]    = gmul(s0, 8'h02) ^ gmul(s1, 8'h03) ^ s2 ^ s3;
            r[32*c+8 +: 8]  = s0 ^ gmul(s1, 8'h02) ^ gmul(s2, 8'h03) ^ s3;
            r[32*c+16 +: 8] = s0 ^ s1 ^ gmul(s2, 8'h02) ^ gmul(s3, 8'h03);
            r[32*c+24 +: 8] = gmul(s0, 8'h03) ^ s1 ^ s2 ^ gmul(s3, 8'h02);
        end
        return r;
    endfunction

    function automatic logic [0:127] mix_inv(input logic [0:127] s);
        logic [0:127] r;
        logic [7:0] s0, s1, s2, s3;
        for (int c = 0; c < 4; c++) begin
            s0 = s[32*c +: 8];
            s1 = s[32*c+8 +: 8];
            s2 = s[32*c+16 +: 8];
            s3 = s[32*c+24 +: 8];
            r[32*c +: 8]    = gmul(s0, 8'h0e) ^ gmul(s1, 8'h0b) ^ gmul(s2, 8'h0d) ^ gmul(s3, 8'h09);
            r[32*c+8 +: 8]  = gmul(s0, 8'h09) ^ gmul(s1, 8'h0e) ^ gmul(s2, 8'h0b) ^ gmul(s3, 8'h0d);
            r[32*c+16 +: 8] = gmul(s0, 8'h0d) ^ gmul(s1, 8'h09) ^ gmul(s2, 8'h0e) ^ gmul(s3, 8'h0b);
            r[32*c+24 +: 8] = gmul(s0, 8'h0b) ^ gmul(s1, 8'h0d) ^ gmul(s2, 8'h09) ^ gmul(s3, 8'h0e);
        end
        return r;
    endfunction

    function automatic logic [0:127] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Scoreboard: every done_flag pops one expected result.
    always @(posedge CLK) begin
        #1;
        if (done_flag) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_done", {127'd0, done_flag}, 128'd0);
            end else begin
                check_val("sb_mixed", mixed, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [0:127] fips_in;
        logic [0:127] fips_exp;
        logic [0:127] x;
        logic [0:127] byp_in;
        int           wait_cnt;

        n_total  = 0;
        n_bad    = 0;
        fips_in  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
        fips_exp = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
        byp_in   = 128'h00112233_44556677_8899aabb_ccddeeff;
        RST      = 1'b0;
        in       = 128'h0;
        enable   = 1'b0;
        bypass   = 1'b0;

        // Reset held with random activity on the inputs.
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            in     = rand128();
            enable = 1'($urandom_range(1, 0));
            #1;
            check_val("rst_mixed", mixed, 128'h0);
            check_val("rst_done", {127'd0, done_flag}, 128'd0);
            check_val("rst_busy", {127'd0, busy}, 128'd0);
        end
        @(negedge CLK);
        enable = 1'b0;
        RST    = 1'b1;

        // FIPS-197 column vectors with cycle-accurate handshake checks.
        @(negedge CLK);
        in     = fips_in;
        enable = 1'b1;
        exp_q.push_back(fips_exp);
        @(negedge CLK);
        enable = 1'b0;
        in     = rand128();
        for (int i = 0; i < 4; i++) begin
            check_val("fips_busy", {127'd0, busy}, 128'd1);
            check_val("fips_done_low", {127'd0, done_flag}, 128'd0);
            @(negedge CLK);
        end
        check_val("fips_busy_end", {127'd0, busy}, 128'd0);
        check_val("fips_done", {127'd0, done_flag}, 128'd1);
        check_val("fips_mixed", mixed, fips_exp);
        @(negedge CLK);
        check_val("fips_done_pulse", {127'd0, done_flag}, 128'd0);
        check_val("fips_hold", mixed, fips_exp);

        // Round trip through the forward MixColumns model.
        for (int k = 0; k < 1000; k++) begin
            x = rand128();
            @(negedge CLK);
            in     = mix_fwd(x);
            enable = 1'b1;
            exp_q.push_back(x);
            @(negedge CLK);
            enable = 1'b0;
            in     = rand128();
            repeat (4) @(negedge CLK);
        end

        // Back-to-back with enable held high and 'in' changing every cycle.
        repeat (2) @(negedge CLK);
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 5; j++) begin
                @(negedge CLK);
                in     = rand128();
                enable = 1'b1;
                if (j == 0) exp_q.push_back(mix_inv(in));
            end
        end
        @(negedge CLK);
        enable = 1'b0;
        repeat (6) @(negedge CLK);
        check_val("b2b_drained", 128'(exp_q.size()), 128'd0);

        // Reset asserted just after a capture aborts the operation.
        @(negedge CLK);
        in     = rand128();
        enable = 1'b1;
        @(negedge CLK);
        enable = 1'b0;
        RST    = 1'b0;
        #1;
        check_val("abort_busy", {127'd0, busy}, 128'd0);
        check_val("abort_mixed", mixed, 128'h0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        repeat (6) @(negedge CLK);
        check_val("abort_no_done", {127'd0, done_flag}, 128'd0);
        x = rand128();
        in     = x;
        enable = 1'b1;
        exp_q.push_back(mix_inv(x));
        @(negedge CLK);
        enable = 1'b0;
        repeat (5) @(negedge CLK);

        // Bypass vector (pass-through only when the feature is built in).
        in     = byp_in;
        enable = 1'b1;
`ifdef INV_MIX_BYPASS_EN
        bypass = 1'b1;
        exp_q.push_back(byp_in);
`else
        exp_q.push_back(mix_inv(byp_in));
`endif
        @(negedge CLK);
        enable = 1'b0;
        bypass = 1'b0;
        in     = rand128();

        // Bounded drain of any outstanding expectations.
        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 20) begin
            @(negedge CLK);
            wait_cnt++;
        end
        check_val("final_drain", 128'(exp_q.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/inv_mix_columns.md
# inv_mix_columns

Iterative AES-128 InvMixColumns stage for the decryption datapath. It is the inverse of the encryption-side MixColumns stage and shares its byte ordering and its `enable`/`done_flag` handshake. It captures a 128-bit state on `enable` and processes one 32-bit column per clock using the GF(2^8) inverse matrix {0e,0b,0d,09}. After four column cycles it presents the full result with a one-cycle `done_flag` pulse. It sits between InvSubBytes/AddRoundKey and the next decryption round in the round controller.

## Interface
- No parameters; widths are fixed by AES-128.
- `CLK`  input  1  rising-edge clock.
- `RST`  input  1  asynchronous, active-low reset.
- `in`  input  [0:127]  state to transform. Byte b occupies bits [8b +: 8]. Column c is bytes 4c..4c+3, with row 0 first.
- `enable`  input  1  start request; sampled only in IDLE.
- `mixed`  output  [0:127]  result register; holds its value until the next completion.
- `done_flag`  output  1  one-cycle pulse; `mixed` is valid while it is high.
- `busy`  output  1  high in COL state.
- `bypass`  input  1  present only when INV_MIX_BYPASS_EN is defined (see Configuration).

## Operation
- States:
  - IDLE: waits for `enable`.
  - COL: 2-bit column counter `col` runs 0..3.
- IDLE with `enable`=1 at a rising edge:
  - capture `in` into internal `state_r`;
  - `col`<=0, go to COL;
  - `busy`<=1.
- IDLE with `enable`=0: nothing changes except `done_flag`<=0.
- COL at each edge:
  - compute column `col` of `state_r` and write it into internal `acc_r` at that column;
  - `col`<=`col`+1.
- Column math (s0..s3 in, r0..r3 out):
  - r0 = 0e·s0 ^ 0b·s1 ^ 0d·s2 ^ 09·s3
  - r1 = 09·s0 ^ 0e·s1 ^ 0b·s2 ^ 0d·s3
  - r2 = 0d·s0 ^ 09·s1 ^ 0e·s2 ^ 0b·s3
  - r3 = 0b·s0 ^ 0d·s1 ^ 09·s2 ^ 0e·s3
- Multiplication: built from xtime (shift left 1, XOR 8'h1b if bit7 was set). 09=x8^x, 0b=x8^x2^x, 0d=x8^x4^x, 0e=x8^x4^x2. All operations are 8-bit; no carries.
- Only one column datapath is instantiated (area is the reason for the iterative design).
- On the edge that processes col=3:
  - `mixed` <= `acc_r` with column 3 included, loaded in one step; `mixed` never shows partial results;
  - `done_flag`<=1, `busy`<=0, go to IDLE.
- `enable` while in COL is ignored; it is neither queued nor an error.
- `in` may change after the capture edge without affecting the result.

## Timing
- Reset (async, RST=0): `mixed`=128'h0, `done_flag`=0, `busy`=0, state=IDLE, `col`=0, `state_r`=`acc_r`=0.
- Reset asserted mid-operation aborts the operation immediately. No `done_flag` is produced for it.
- Latency: `enable` is sampled at edge E0. Columns 0..3 are processed at edges E1..E4. `mixed` and `done_flag` update at E4. `done_flag` is high for the cycle E4..E5.
- Throughput: a new `enable` may be high during the `done_flag` cycle. It is accepted at E5, giving one result every 5 cycles.
- `busy` is high from E0 to E4, covering four cycles.
- `done_flag` is 0 in every cycle that does not follow a completion edge.

## Configuration
- Macro: INV_MIX_BYPASS_EN.
- Defined:
  - adds input `bypass`, sampled with `enable` at capture and held for the whole operation;
  - if `bypass`=1, the column datapath is skipped and `mixed` = captured `in`. Latency and handshake are identical (4 column cycles plus `done_flag`).
  - The round controller uses this for the decryption round that has no InvMixColumns.
- Undefined: no `bypass` port and no bypass logic; every operation applies InvMixColumns.

## Test plan
- Reset: hold RST=0 with random `in` and `enable` toggling -> `mixed`=0, `done_flag`=0, `busy`=0 throughout.
- FIPS vectors: `in`=8e4da1bc_9fdc589d_01010101_d5d5d7d6, `enable` pulsed one cycle -> after 4 edges `mixed`=db135345_f20a225c_01010101_d4d4d4d5, `done_flag` high exactly one cycle, `busy` high 4 cycles.
- Round trip: random state X goes through MixColumns and then this block -> `mixed`=X; run 1000 iterations.
- Ignored enable/back-to-back: hold `enable`=1 continuously with `in` changing every cycle -> results every 5 cycles, each matching the `in` value at its capture edge.
- Reset mid-op: assert RST at the edge after capture, release, then issue a new `enable` -> no `done_flag` from the aborted op; the new op completes correctly.
- Bypass (INV_MIX_BYPASS_EN): `bypass`=1 with `in`=00112233_44556677_8899aabb_ccddeeff -> `mixed` equals `in` after 4 edges. With the macro undefined, the same stimulus minus `bypass` gives the InvMixColumns result.
